// File: rtl/riffa_tx_chnl_arbiter.sv
// riffa_tx_chnl_arbiter
// Shares one RIFFA TX channel (FPGA->host) among C_NUM_REQ requesters, each
// presenting a full RIFFA TX-side interface. Whole transactions are granted
// round-robin. The winner is muxed onto CHNL_TX_*, and ACK/DATA_REN are routed back
// to the winner only. Beats are counted against ceil(LEN/WPB) to find the end
// of a transaction.
//
// Ports
//   CLK, RST_N              clock, asynchronous active-low reset
//   REQ_TX*                 per-requester RIFFA TX inputs (slot i at [W*i +: W])
//   REQ_TX_ACK/DATA_REN     per-requester returns, granted slot only
//   CHNL_TX*                muxed RIFFA TX channel toward the host
//   CHNL_TX_ACK/DATA_REN    returns from RIFFA
//   GNT                     one-hot grant, 0 when idle
//   ABORT                   one-cycle pulse when the granted requester quits early
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no grant; pick next requester starting at the rr pointer
// WAIT_ACK | CHNL_TX up with granted LEN/OFF/LAST, waiting for RIFFA ACK
// XFER     | counting beats until need is reached or the requester drops
// DONE     | one cycle with CHNL_TX low; advance rr pointer, release grant
module riffa_tx_chnl_arbiter #(
    parameter int C_PCI_DATA_WIDTH = 128,
    parameter int C_NUM_REQ        = 4
) (
    input  logic                                  CLK,
    input  logic                                  RST_N,
    input  logic [C_NUM_REQ-1:0]                  REQ_TX,
    input  logic [C_NUM_REQ-1:0]                  REQ_TX_LAST,
    input  logic [32*C_NUM_REQ-1:0]               REQ_TX_LEN,
    input  logic [31*C_NUM_REQ-1:0]               REQ_TX_OFF,
    input  logic [C_PCI_DATA_WIDTH*C_NUM_REQ-1:0] REQ_TX_DATA,
    input  logic [C_NUM_REQ-1:0]                  REQ_TX_DATA_VALID,
    output logic [C_NUM_REQ-1:0]                  REQ_TX_ACK,
    output logic [C_NUM_REQ-1:0]                  REQ_TX_DATA_REN,
    output logic                                  CHNL_TX,
    output logic                                  CHNL_TX_LAST,
    output logic [31:0]                           CHNL_TX_LEN,
    output logic [30:0]                           CHNL_TX_OFF,
    output logic [C_PCI_DATA_WIDTH-1:0]           CHNL_TX_DATA,
    output logic                                  CHNL_TX_DATA_VALID,
    input  logic                                  CHNL_TX_ACK,
    input  logic                                  CHNL_TX_DATA_REN,
    output logic [C_NUM_REQ-1:0]                  GNT,
    output logic                                  ABORT
);

    localparam int W       = C_PCI_DATA_WIDTH;
    localparam int N       = C_NUM_REQ;
    localparam int WPB     = C_PCI_DATA_WIDTH / 32;
    localparam int WPB_LOG = $clog2(WPB);
    localparam int IW      = $clog2(C_NUM_REQ);
    localparam logic [32:0] WPB_M1 = 33'(WPB - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_ACK = 2'd1,
        S_XFER     = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [31:0]     need_q, need_d;
    logic [30:0]     cnt_q, cnt_d;
    logic            abort_q, abort_d;

    logic            pick_vld;
    logic [IW-1:0]   pick_idx;
    logic [31:0]     pick_len;
    int              pick_j;
    logic [32:0]     need_sum;
    logic [32:0]     need_shr;
    logic [31:0]     need_new;

    logic            mux_last;
    logic [31:0]     mux_len;
    logic [30:0]     mux_off;
    logic [W-1:0]    mux_data;
    logic            mux_vld;

    logic            active;
    logic            beat;
    logic            req_g;
    logic [30:0]     cnt_inc;
    logic            cnt_hit;

    // Round-robin search starting at rr_q, wrapping N-1 -> 0.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        pick_len = '0;
        pick_j   = 0;
        for (int k = 0; k < N; k++) begin
            pick_j = int'(rr_q) + k;
            if (pick_j >= N) pick_j = pick_j - N;
            if (!pick_vld && REQ_TX[pick_j]) begin
                pick_vld = 1'b1;
                pick_idx = IW'(pick_j);
                pick_len = REQ_TX_LEN[32*pick_j +: 32];
            end
        end
    end

    // ceil(LEN/WPB) with a 33-bit sum so LEN near 2^32 does not wrap.
    assign need_sum = {1'b0, pick_len} + WPB_M1;
    assign need_shr = need_sum >> WPB_LOG;
    assign need_new = need_shr[31:0];

    // AND-OR mux keyed on the one-hot grant; everything is 0 with no grant.
    always_comb begin
        mux_last = 1'b0;
        mux_len  = '0;
        mux_off  = '0;
        mux_data = '0;
        mux_vld  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (gnt_q[i]) begin
                mux_last = mux_last | REQ_TX_LAST[i];
                mux_len  = mux_len  | REQ_TX_LEN[32*i +: 32];
                mux_off  = mux_off  | REQ_TX_OFF[31*i +: 31];
                mux_data = mux_data | REQ_TX_DATA[W*i +: W];
                mux_vld  = mux_vld  | REQ_TX_DATA_VALID[i];
            end
        end
    end

    assign active             = (state_q == S_WAIT_ACK) || (state_q == S_XFER);
    assign CHNL_TX            = active;
    assign CHNL_TX_LAST       = mux_last & active;
    assign CHNL_TX_LEN        = active ? mux_len : '0;
    assign CHNL_TX_OFF        = active ? mux_off : '0;
    assign CHNL_TX_DATA       = mux_data;
    assign CHNL_TX_DATA_VALID = mux_vld & active;
    assign REQ_TX_ACK         = gnt_q & {N{CHNL_TX_ACK && (state_q == S_WAIT_ACK)}};
    assign REQ_TX_DATA_REN    = gnt_q & {N{CHNL_TX_DATA_REN && active}};
    assign GNT                = gnt_q;
    assign ABORT              = abort_q;

    assign beat  = CHNL_TX_DATA_VALID & CHNL_TX_DATA_REN;
    assign req_g = |(REQ_TX & gnt_q);

    // Counter saturates at need so beats past the end cannot wrap it.
    always_comb begin
        cnt_inc = cnt_q;
        if (beat && ({1'b0, cnt_q} < need_q)) cnt_inc = cnt_q + 31'd1;
        cnt_hit = ({1'b0, cnt_inc} >= need_q);
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        need_d  = need_q;
        cnt_d   = cnt_q;
        abort_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (pick_vld) begin
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    idx_d           = pick_idx;
                    need_d          = need_new;
                    state_d         = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                // A beat alongside ACK is legal and counts here.
                cnt_d = cnt_inc;
                if (CHNL_TX_ACK) begin
                    state_d = cnt_hit ? S_DONE : S_XFER;
                end else if (!req_g) begin
                    gnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_XFER: begin
                cnt_d = cnt_inc;
                if (cnt_hit) begin
                    state_d = S_DONE;
                end else if (!req_g) begin
                    abort_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                gnt_d   = '0;
                rr_d    = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            rr_q    <= '0;
            need_q  <= '0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            need_q  <= need_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
        end
    end

endmodule

// File: tb/tb_riffa_tx_chnl_arbiter.sv
// Testbench for riffa_tx_chnl_arbiter: requester and RIFFA host models,
// expected transactions queued as stimulus is issued and compared when each
// transaction on CHNL_TX completes.
module tb_riffa_tx_chnl_arbiter;

    localparam int N = 4;
    localparam int W = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   req_tx, req_last, req_vld, req_ack, req_ren, gnt;
    logic [32*N-1:0] req_len;
    logic [31*N-1:0] req_off;
    logic [W*N-1:0] req_data;
    logic           chnl_tx, chnl_last, chnl_vld, abort;
    logic [31:0]    chnl_len;
    logic [30:0]    chnl_off;
    logic [W-1:0]   chnl_data;
    logic           host_ack = 1'b0;
    logic           host_ren = 1'b0;
    bit             ren_toggle = 1'b0;
    bit             acked = 1'b0;

    int          pend[N];
    int          served[N];
    bit          drop[N];
    bit          vld_en[N];
    logic [31:0] len_cfg[N];

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [N-1:0] gnt;
        int           beats;
        logic         abort;
        logic [31:0]  len;
        logic [W-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    exp_t push_e;

    riffa_tx_chnl_arbiter #(.C_PCI_DATA_WIDTH(W), .C_NUM_REQ(N)) dut (
        .CLK(clk),
        .RST_N(rst_n),
        .REQ_TX(req_tx),
        .REQ_TX_LAST(req_last),
        .REQ_TX_LEN(req_len),
        .REQ_TX_OFF(req_off),
        .REQ_TX_DATA(req_data),
        .REQ_TX_DATA_VALID(req_vld),
        .REQ_TX_ACK(req_ack),
        .REQ_TX_DATA_REN(req_ren),
        .CHNL_TX(chnl_tx),
        .CHNL_TX_LAST(chnl_last),
        .CHNL_TX_LEN(chnl_len),
        .CHNL_TX_OFF(chnl_off),
        .CHNL_TX_DATA(chnl_data),
        .CHNL_TX_DATA_VALID(chnl_vld),
        .CHNL_TX_ACK(host_ack),
        .CHNL_TX_DATA_REN(host_ren),
        .GNT(gnt),
        .ABORT(abort)
    );

    function automatic logic [W-1:0] dpat(input int i);
        return {4{32'hD000_0000 + 32'(i)}};
    endfunction

    task automatic chk_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requester models: slot i requests while it has unserved transactions.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_tx[i]              = (pend[i] > served[i]) && !drop[i];
            req_vld[i]             = req_tx[i] && vld_en[i];
            req_last[i]            = 1'b1;
            req_len[32*i +: 32]    = len_cfg[i];
            req_off[31*i +: 31]    = 31'(16 * i);
            req_data[W*i +: W]     = dpat(i);
        end
    end

    // RIFFA host: ACK for one cycle as soon as CHNL_TX is seen, REN from the ACK cycle on.
    initial forever begin
        @(posedge clk);
        #1;
        if (!rst_n || !chnl_tx) begin
            host_ack = 1'b0;
            host_ren = 1'b0;
            acked    = 1'b0;
        end else if (!acked) begin
            host_ack = 1'b1;
            host_ren = 1'b1;
            acked    = 1'b1;
        end else begin
            host_ack = 1'b0;
            host_ren = ren_toggle ? !host_ren : 1'b1;
        end
    end

    // Monitor: track a transaction from CHNL_TX rise to fall and score it.
    bit           in_tx = 1'b0;
    logic [N-1:0] cur_gnt;
    logic [31:0]  cur_len;
    int           beats;
    logic [W-1:0] first_data;
    bit           leak;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            in_tx = 1'b0;
        end else begin
            if (in_tx && !chnl_tx) begin
                chk_val("sb_nonempty", W'(sb.size() > 0), W'(1));
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    chk_val("gnt",   W'(cur_gnt), W'(mon_e.gnt));
                    chk_val("beats", W'(beats),   W'(mon_e.beats));
                    chk_val("abort", W'(abort),   W'(mon_e.abort));
                    chk_val("len",   W'(cur_len), W'(mon_e.len));
                    chk_val("leak",  W'(leak),    W'(0));
                    if (beats > 0) chk_val("data", first_data, mon_e.data);
                end
                for (int i = 0; i < N; i++) if (cur_gnt[i]) served[i]++;
                in_tx = 1'b0;
            end else if (!in_tx && chnl_tx) begin
                in_tx      = 1'b1;
                cur_gnt    = gnt;
                cur_len    = chnl_len;
                beats      = 0;
                leak       = 1'b0;
                first_data = '0;
            end
            if (in_tx) begin
                if (chnl_vld && host_ren) begin
                    if (beats == 0) first_data = chnl_data;
                    beats++;
                end
                if (((req_ack | req_ren) & ~gnt) != '0) leak = 1'b1;
            end
        end
    end

    task automatic push_exp(input logic [N-1:0] g, input int b, input logic ab, input logic [31:0] l, input int slot);
        push_e.gnt   = g;
        push_e.beats = b;
        push_e.abort = ab;
        push_e.len   = l;
        push_e.data  = dpat(slot);
        sb.push_back(push_e);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #2;
            if (sb.size() == 0 && !in_tx) break;
        end
        chk_val(tag, W'(sb.size()), W'(0));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic logic any_out();
        return |{req_ack, req_ren, chnl_tx, chnl_last, chnl_len, chnl_off,
                 chnl_data, chnl_vld, gnt, abort};
    endfunction

    initial begin
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; served[i] = 0; drop[i] = 1'b0; vld_en[i] = 1'b1; len_cfg[i] = 32'd4;
        end
        #1;
        chk_val("rst_outs", W'(any_out()), W'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset in the middle of a transfer
        len_cfg[1] = 32'd40;
        pend[1] = served[1] + 1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (req_ren[1]) break;
        end
        chk_val("t1_in_xfer", W'(req_ren[1]), W'(1));
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk_val("t1_rst_outs", W'(any_out()), W'(0));
        pend[1] = served[1];
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_val("t1_gnt_idle", W'(gnt), W'(0));
        chk_val("t1_tx_idle", W'(chnl_tx), W'(0));

        // single requester, LEN=10 -> 3 beats
        len_cfg[1] = 32'd10;
        push_exp(4'b0010, 3, 1'b0, 32'd10, 1);
        pend[1] = pend[1] + 1;
        wait_drain("t2_drain", 200);

        // all four request, LEN=4 -> order 0,1,2,3,0
        do_reset();
        for (int i = 0; i < N; i++) len_cfg[i] = 32'd4;
        push_exp(4'b0001, 1, 1'b0, 32'd4, 0);
        push_exp(4'b0010, 1, 1'b0, 32'd4, 1);
        push_exp(4'b0100, 1, 1'b0, 32'd4, 2);
        push_exp(4'b1000, 1, 1'b0, 32'd4, 3);
        push_exp(4'b0001, 1, 1'b0, 32'd4, 0);
        pend[0] = pend[0] + 2;
        pend[1] = pend[1] + 1;
        pend[2] = pend[2] + 1;
        pend[3] = pend[3] + 1;
        wait_drain("t3_drain", 300);

        // LEN=0 on slot 2, then rr pointer must start at 3
        do_reset();
        vld_en[2]  = 1'b0;
        len_cfg[2] = 32'd0;
        push_exp(4'b0100, 0, 1'b0, 32'd0, 2);
        pend[2] = pend[2] + 1;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #2;
            if (gnt == 4'b0100) break;
        end
        chk_val("t4_gnt2", W'(gnt), W'(4'b0100));
        push_exp(4'b1000, 1, 1'b0, 32'd4, 3);
        push_exp(4'b0001, 1, 1'b0, 32'd4, 0);
        push_exp(4'b0010, 1, 1'b0, 32'd4, 1);
        pend[3] = pend[3] + 1;
        pend[0] = pend[0] + 1;
        pend[1] = pend[1] + 1;
        wait_drain("t4_drain", 300);
        vld_en[2]  = 1'b1;
        len_cfg[2] = 32'd4;

        // slot 0 quits after 1 of 3 beats -> ABORT, then slot 1
        do_reset();
        len_cfg[0] = 32'd12;
        len_cfg[1] = 32'd12;
        push_exp(4'b0001, 1, 1'b1, 32'd12, 0);
        push_exp(4'b0010, 3, 1'b0, 32'd12, 1);
        pend[0] = pend[0] + 1;
        pend[1] = pend[1] + 1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (req_ack[0]) break;
        end
        chk_val("t5_ack0", W'(req_ack[0]), W'(1));
        @(posedge clk);
        #1 drop[0] = 1'b1;
        wait_drain("t5_drain", 200);
        drop[0] = 1'b0;
        pend[0] = served[0];

        // toggling REN, LEN=13 -> 4 beats each, two requesters
        do_reset();
        ren_toggle = 1'b1;
        len_cfg[1] = 32'd13;
        len_cfg[3] = 32'd13;
        push_exp(4'b0010, 4, 1'b0, 32'd13, 1);
        push_exp(4'b1000, 4, 1'b0, 32'd13, 3);
        pend[1] = pend[1] + 1;
        pend[3] = pend[3] + 1;
        wait_drain("t6_drain", 300);
        ren_toggle = 1'b0;

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
